// File: rtl/hazard_tracker.sv
// -----------------------------------------------------------------------------
// hazard_tracker
//
// Keeps a small shadow of the destination-register tags flowing down the
// ID/EX, EX/MEM and MEM/WB pipeline stages. It provides three things:
//   * registered EX/MEM and MEM/WB destination tags for the forwarding unit,
//   * a combinational load-use stall request,
//   * an optional saturating count of load-use stall cycles.
//
// Optional feature macro: HAZARD_STATS_EN
//   defined   -> stall_count increments once per stall cycle, saturating at
//                16'hFFFF
//   undefined -> stall_count is tied to 16'h0000 and no counter is built
//
// Parameters
//   REG_BITS      register-index width (default 5, i.e. 32 registers)
//
// Ports
//   clk           single clock, all state updates on the rising edge
//   rst_n         asynchronous, active-low reset
//   id_valid      the IF/ID instruction is real (not a bubble)
//   id_rd         destination register of the IF/ID instruction
//   id_regWrEn    the IF/ID instruction writes rd
//   id_memRead    the IF/ID instruction is a load
//   id_rs1/rs2    source registers of the IF/ID instruction
//   id_use_rs1/2  the corresponding source is actually read
//   flush         taken branch resolved in EX; kill the IF/ID instruction
//   rd_ex         EX/MEM destination register (to forwarding)
//   regWrEn       EX/MEM write enable (to forwarding)
//   rd_mem        MEM/WB destination register (to forwarding)
//   regWrEn_mem   MEM/WB write enable (to forwarding)
//   stall         hold the PC and IF/ID this cycle
//   stall_count   load-use stall cycles counted
// -----------------------------------------------------------------------------
module hazard_tracker #(
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_regWrEn,
  input  logic                id_memRead,
  input  logic [REG_BITS-1:0] id_rs1,
  input  logic [REG_BITS-1:0] id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic                flush,
  output logic [REG_BITS-1:0] rd_ex,
  output logic                regWrEn,
  output logic [REG_BITS-1:0] rd_mem,
  output logic                regWrEn_mem,
  output logic                stall,
  output logic [15:0]         stall_count
);

  // One pipeline tag: destination register, writes-rd flag, is-load flag.
  typedef struct packed {
    logic [REG_BITS-1:0] rd;
    logic                wr;
    logic                load;
  } tag_t;

  localparam tag_t BUBBLE = '{rd: '0, wr: 1'b0, load: 1'b0};

  tag_t id_ex;
  tag_t ex_mem;
  tag_t mem_wb;

  tag_t id_entry;     // what ID/EX captures at the next edge
  logic rs1_match;
  logic rs2_match;
  logic load_use;

  // ---------------------------------------------------------------------------
  // Load-use detection and next ID/EX entry
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven in always_comb gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    rs1_match = 1'b0;
    rs2_match = 1'b0;
    load_use  = 1'b0;
    id_entry  = BUBBLE;

    rs1_match = id_use_rs1 && (id_rs1 == id_ex.rd);
    rs2_match = id_use_rs2 && (id_rs2 == id_ex.rd);

    // Only a load still in ID/EX can't be covered by forwarding: its data
    // appears one stage too late. Writes to x0 never create a dependency.
    load_use = id_ex.load && id_ex.wr && (id_ex.rd != '0) && id_valid &&
               (rs1_match || rs2_match);

    // A taken branch kills the IF/ID instruction, so holding it is pointless.
    stall = load_use && !flush;

    // The write enable is stripped at insertion when rd is x0, so both
    // downstream stages inherit a clean enable and the forwarding unit never
    // sees a write to x0.
    if (id_valid && !stall && !flush) begin
      id_entry.rd   = id_rd;
      id_entry.wr   = id_regWrEn && (id_rd != '0);
      id_entry.load = id_memRead;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline: shifts every cycle; a stall inserts a bubble into ID/EX
  // while the held instruction retries from IF/ID next cycle.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so all three stages
  // sample their predecessors' old values at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex  <= BUBBLE;
      ex_mem <= BUBBLE;
      mem_wb <= BUBBLE;
    end else begin
      id_ex  <= id_entry;
      ex_mem <= id_ex;
      mem_wb <= ex_mem;
    end
  end

  // Forwarding outputs come straight from stage registers.
  assign rd_ex       = ex_mem.rd;
  assign regWrEn     = ex_mem.wr;
  assign rd_mem      = mem_wb.rd;
  assign regWrEn_mem = mem_wb.wr;

  // ---------------------------------------------------------------------------
  // Optional stall statistics
  // ---------------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// -----------------------------------------------------------------------------
// tb_hazard_tracker
//
// Scoreboarded bench for hazard_tracker. The driver applies one instruction
// slot per cycle, derives the expected outputs for that cycle from a history
// of accepted instructions, and queues them; a monitor pops and compares on
// every falling edge. Directed scenarios run first, then a random stream.
// Build with HAZARD_STATS_EN defined to exercise the stall counter, including
// saturation.
// -----------------------------------------------------------------------------
module tb_hazard_tracker;

  localparam int RB = 5;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [RB-1:0] id_rd;
  logic          id_regWrEn;
  logic          id_memRead;
  logic [RB-1:0] id_rs1;
  logic [RB-1:0] id_rs2;
  logic          id_use_rs1;
  logic          id_use_rs2;
  logic          flush;
  logic [RB-1:0] rd_ex;
  logic          regWrEn;
  logic [RB-1:0] rd_mem;
  logic          regWrEn_mem;
  logic          stall;
  logic [15:0]   stall_count;

  hazard_tracker #(.REG_BITS(RB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rd       (id_rd),
    .id_regWrEn  (id_regWrEn),
    .id_memRead  (id_memRead),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .flush       (flush),
    .rd_ex       (rd_ex),
    .regWrEn     (regWrEn),
    .rd_mem      (rd_mem),
    .regWrEn_mem (regWrEn_mem),
    .stall       (stall),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  // An instruction as the architecture sees it after it leaves ID.
  typedef struct {
    int unsigned rd;
    bit          writes;   // architecturally visible write (never x0)
    bit          load;
  } instr_t;

  typedef struct {
    bit          stall;
    int unsigned rd_ex;
    bit          wr_ex;
    int unsigned rd_mem;
    bit          wr_mem;
    int unsigned cnt;
  } expect_t;

  // hist[k] = instruction that left ID k+1 cycles ago (bubble if none).
  instr_t      hist[$];
  expect_t     exp_q[$];
  int unsigned exp_cnt;
  bit          cur_stall;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    instr_t b;
    b = '{rd: 0, writes: 1'b0, load: 1'b0};
    hist.delete();
    repeat (3) hist.push_back(b);
    exp_cnt = 0;
  endfunction

  // Apply one IF/ID slot (called just after a rising edge) and queue the
  // outputs the design must show during this cycle.
  task automatic issue(input bit v, input int unsigned rd, input bit wr,
                       input bit ld, input int unsigned r1, input int unsigned r2,
                       input bit u1, input bit u2, input bit fl);
    expect_t e;
    bit      dep;
    id_valid   = v;
    id_rd      = RB'(rd);
    id_regWrEn = wr;
    id_memRead = ld;
    id_rs1     = RB'(r1);
    id_rs2     = RB'(r2);
    id_use_rs1 = u1;
    id_use_rs2 = u2;
    flush      = fl;
    // A load issued last cycle cannot feed a dependent instruction now.
    dep = v && hist[0].load && hist[0].writes &&
          ((u1 && r1 == hist[0].rd) || (u2 && r2 == hist[0].rd));
    e.stall  = dep && !fl;
    e.rd_ex  = hist[1].rd;
    e.wr_ex  = hist[1].writes;
    e.rd_mem = hist[2].rd;
    e.wr_mem = hist[2].writes;
    e.cnt    = STATS ? exp_cnt : 0;
    exp_q.push_back(e);
    cur_stall = e.stall;
  endtask

  // Clock edge: record which instruction (if any) left ID.
  task automatic tick();
    instr_t n;
    @(posedge clk);
    if (id_valid && !cur_stall && !flush)
      n = '{rd: id_rd, writes: id_regWrEn && (id_rd != 0), load: id_memRead};
    else
      n = '{rd: 0, writes: 1'b0, load: 1'b0};
    hist.push_front(n);
    void'(hist.pop_back());
    if (cur_stall && exp_cnt < 65535) exp_cnt++;
    #1;
  endtask

  task automatic step(input bit v, input int unsigned rd, input bit wr,
                      input bit ld, input int unsigned r1, input int unsigned r2,
                      input bit u1, input bit u2, input bit fl);
    issue(v, rd, wr, ld, r1, r2, u1, u2, fl);
    tick();
  endtask

  task automatic bubble();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rd = '0; id_regWrEn = 0; id_memRead = 0;
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0; flush = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_ex"},       32'(rd_ex),       0);
    check({tag, "_regWrEn"},     32'(regWrEn),     0);
    check({tag, "_rd_mem"},      32'(rd_mem),      0);
    check({tag, "_regWrEn_mem"}, 32'(regWrEn_mem), 0);
    check({tag, "_stall"},       32'(stall),       0);
    check({tag, "_stall_count"}, 32'(stall_count), 0);
  endtask

  // Monitor: compares every cycle the scoreboard has an expectation for.
  always @(negedge clk) begin
    expect_t e;
    if (rst_n === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("mon_stall",       32'(stall),       32'(e.stall));
      check("mon_rd_ex",       32'(rd_ex),       e.rd_ex);
      check("mon_regWrEn",     32'(regWrEn),     32'(e.wr_ex));
      check("mon_rd_mem",      32'(rd_mem),      e.rd_mem);
      check("mon_regWrEn_mem", 32'(regWrEn_mem), 32'(e.wr_mem));
      check("mon_stall_count", 32'(stall_count), e.cnt);
    end
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cnt_before;
    bit          held;
    int unsigned h_rd, h_r1, h_r2;
    bit          h_v, h_wr, h_ld, h_u1, h_u2;

    // ---------------- reset ----------------
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #23;
    check_all_zero("reset");
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- ALU producer latency ----------------
    step(1, 5, 1, 0, 1, 2, 1, 1, 0);      // add x5,x1,x2 in ID at cycle 0
    bubble();
    check("lat_rd_ex_c2",      32'(rd_ex), 5);
    check("lat_regWrEn_c2",    32'(regWrEn), 1);
    bubble();
    check("lat_rd_mem_c3",     32'(rd_mem), 5);
    check("lat_regWrEn_mem_c3", 32'(regWrEn_mem), 1);
    check("lat_regWrEn_c3",    32'(regWrEn), 0);
    bubble();

    // ---------------- load-use: lw x5 ; add x6,x5,x7 ----------------
    cnt_before = exp_cnt;
    step(1, 5, 1, 1, 0, 0, 1, 0, 0);      // lw x5
    issue(1, 6, 1, 0, 5, 7, 1, 1, 0);     // add x6,x5,x7
    #1 check("lu_stall", 32'(stall), 1);
    tick();
    issue(1, 6, 1, 0, 5, 7, 1, 1, 0);     // same add, held in IF/ID
    #1 check("lu_stall_cleared", 32'(stall), 0);
    check("lu_rd_ex_is_load", 32'(rd_ex), 5);
    tick();
    check("lu_bubble_rd_ex",   32'(rd_ex), 0);
    check("lu_bubble_regWrEn", 32'(regWrEn), 0);
    check("lu_stall_count", 32'(stall_count), STATS ? cnt_before + 1 : 0);
    bubble(); bubble(); bubble();

    // ---------------- non-load producer never stalls ----------------
    step(1, 9, 1, 0, 0, 0, 0, 0, 0);      // add x9
    issue(1, 10, 1, 0, 9, 9, 1, 1, 0);    // add x10,x9,x9
    #1 check("alu_no_stall", 32'(stall), 0);
    tick();
    bubble(); bubble();

    // ---------------- lw x0 ; add x6,x0,x0 ----------------
    step(1, 0, 1, 1, 0, 0, 1, 0, 0);
    issue(1, 6, 1, 0, 0, 0, 1, 1, 0);
    #1 check("x0_no_stall", 32'(stall), 0);
    tick();
    check("x0_rd_ex", 32'(rd_ex), 0);
    check("x0_regWrEn", 32'(regWrEn), 0);
    bubble(); bubble(); bubble();

    // ---------------- load-use killed by flush ----------------
    cnt_before = exp_cnt;
    step(1, 5, 1, 1, 0, 0, 1, 0, 0);
    issue(1, 6, 1, 0, 7, 5, 1, 1, 1);     // dependent, but flushed
    #1 check("flush_stall", 32'(stall), 0);
    tick();
    issue(1, 6, 1, 0, 7, 5, 1, 1, 0);
    #1 check("flush_bubble_no_stall", 32'(stall), 0);
    tick();
    check("flush_no_count", 32'(stall_count), STATS ? cnt_before : 0);
    bubble(); bubble(); bubble();

    // ---------------- asynchronous reset mid-stream ----------------
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 2, 1, 0, 0, 0, 0, 0, 0);
    step(1, 3, 1, 1, 0, 0, 0, 0, 0);
    issue(1, 4, 1, 0, 3, 0, 1, 0, 0);     // would stall on the lw x3
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1 check_all_zero("async_rst");
    idle_inputs();
    @(posedge clk); #3 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    bubble();
    check("post_rst_rd_ex", 32'(rd_ex), 0);
    check("post_rst_rd_mem", 32'(rd_mem), 0);
    step(1, 12, 1, 0, 0, 0, 0, 0, 0);
    bubble();
    check("post_rst_lat_rd_ex", 32'(rd_ex), 12);
    bubble();
    check("post_rst_lat_rd_mem", 32'(rd_mem), 12);

    // ---------------- random stream ----------------
    held = 1'b0;
    h_v = 0; h_rd = 0; h_wr = 0; h_ld = 0; h_r1 = 0; h_r2 = 0; h_u1 = 0; h_u2 = 0;
    for (int i = 0; i < 1500; i++) begin
      // A stalled instruction is held in IF/ID; otherwise fetch a new one.
      if (!held) begin
        h_v  = ($urandom_range(0, 7) != 0);
        h_rd = $urandom_range(0, 7);
        h_wr = ($urandom_range(0, 4) != 0);
        h_ld = ($urandom_range(0, 2) == 0);
        h_r1 = $urandom_range(0, 7);
        h_r2 = $urandom_range(0, 7);
        h_u1 = $urandom_range(0, 1);
        h_u2 = $urandom_range(0, 1);
      end
      step(h_v, h_rd, h_wr, h_ld, h_r1, h_r2, h_u1, h_u2,
           ($urandom_range(0, 15) == 0));
      held = cur_stall;
    end
    bubble(); bubble(); bubble();

`ifdef HAZARD_STATS_EN
    // ---------------- counter saturation ----------------
    // A self-dependent load held in IF/ID stalls on every other cycle.
    for (int i = 0; i < 131080; i++) step(1, 5, 1, 1, 5, 0, 1, 0, 0);
    check("sat_stall_count", 32'(stall_count), 32'h0000_FFFF);
    step(1, 5, 1, 1, 5, 0, 1, 0, 0);
    step(1, 5, 1, 1, 5, 0, 1, 0, 0);
    check("sat_hold", 32'(stall_count), 32'h0000_FFFF);
`else
    check("stats_off_tied", 32'(stall_count), 0);
`endif

    idle_inputs();
    @(negedge clk); #1;
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
